// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// default timeout and the round-robin search used by the picker.
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 50000;
    localparam int MAX_REQ            = 8;

    // First set bit of mask at or after ptr, wrapping at n-1; 0 when mask is empty.
    function automatic logic [2:0] next_rr_idx(
        input logic [2:0] ptr,
        input logic [7:0] mask,
        input int         n
    );
        logic [2:0] idx;
        logic       found;
        logic [3:0] pos;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(n)) begin
                pos = pos - 4'(n);
            end
            if (!found && (k < n) && mask[pos[2:0]]) begin
                idx   = pos[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Successor of idx in a ring of n requesters.
    function automatic logic [2:0] wrap_inc(
        input logic [2:0] idx,
        input int         n
    );
        logic [2:0] nxt;
        if (32'(idx) == n - 1) begin
            nxt = '0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: picks the first valid requester at or
// after rr_ptr, wrapping around the ring.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               sel_any
);

    logic [MAX_REQ-1:0] mask_pad;
    logic [2:0]         ptr_pad;
    logic [2:0]         pick;

    always_comb begin
        mask_pad                = '0;
        mask_pad[NUM_REQ-1:0]   = req_valid;
    end

    assign ptr_pad = 3'(rr_ptr);
    assign pick    = next_rr_idx(ptr_pad, mask_pad, NUM_REQ);
    assign sel_idx = IDX_W'(pick);
    assign sel_any = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte streams with round-robin grants that
// stay locked until a last byte, plus a stall timeout that forces release.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout_pulse
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_pulse_q, timeout_pulse_d;

    logic [7:0]       req_byte [NUM_REQ];
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             locked;
    logic             g_valid;
    logic             g_last;
    logic             handshake;
    logic             timeout_hit;
    logic [IDX_W-1:0] ptr_after_g;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .sel_idx   (sel_idx),
        .sel_any   (sel_any)
    );

    assign locked      = (state_q == LOCKED);
    assign g_valid     = req_valid[grant_idx_q];
    assign g_last      = req_last[grant_idx_q];
    assign handshake   = locked && g_valid && tx_ready;
    // Only a silent holder ages; UART backpressure with valid high never counts.
    assign timeout_hit = locked && !g_valid && (to_cnt_q == TO_LAST);
    assign ptr_after_g = IDX_W'(wrap_inc(3'(grant_idx_q), NUM_REQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_idx_q     <= '0;
            rr_ptr_q        <= '0;
            to_cnt_q        <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_idx_q     <= grant_idx_d;
            rr_ptr_q        <= rr_ptr_d;
            to_cnt_q        <= to_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_idx_d     = grant_idx_q;
        rr_ptr_d        = rr_ptr_q;
        to_cnt_d        = to_cnt_q;
        timeout_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_d     = LOCKED;
                    grant_idx_d = sel_idx;
                    to_cnt_d    = '0;
                end
            end
            LOCKED: begin
                if (handshake && g_last) begin
                    state_d     = IDLE;
                    grant_idx_d = '0;
                    rr_ptr_d    = ptr_after_g;
                    to_cnt_d    = '0;
                end else if (g_valid) begin
                    to_cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d         = IDLE;
                    grant_idx_d     = '0;
                    rr_ptr_d        = ptr_after_g;
                    to_cnt_d        = '0;
                    timeout_pulse_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                grant_idx_d = '0;
            end
        endcase
    end

    // Data path is a pure mux on the holder so no latency is added per byte.
    always_comb begin
        tx_valid      = locked && g_valid;
        tx_data       = locked ? req_byte[grant_idx_q] : 8'h00;
        grant_valid   = locked;
        grant_idx     = grant_idx_q;
        timeout_pulse = timeout_pulse_q;
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = locked && (grant_idx_q == IDX_W'(gi)) && tx_ready;
        end
    endgenerate

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a negedge
// monitor logging handshakes/grants/pulses, and one task per scenario.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic        timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (20),
        .TO_W           (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] bd [4][16];
    logic       bl [4][16];
    int         head [4];
    int         tail [4];

    int lg_idx[$], lg_data[$], lg_cyc[$];
    int pulse_cyc[$], gnt_idx_q[$], gnt_cyc[$], gnt_end[$];
    logic prev_gv = 1'b0;
    logic [3:0] cap;

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = bd[i][head[i]];
                req_last[i]        = bl[i][head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        bd[r][tail[r]] = d;
        bl[r][tail[r]] = l;
        tail[r]++;
        refresh();
    endtask

    task automatic clear_bufs();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        refresh();
    endtask

    task automatic clear_logs();
        lg_idx.delete(); lg_data.delete(); lg_cyc.delete();
        pulse_cyc.delete(); gnt_idx_q.delete(); gnt_cyc.delete(); gnt_end.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_bufs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_logs();
    endtask

    // Monitor and requester model: sample at negedge, advance queues after posedge.
    initial begin
        forever begin
            @(negedge clk);
            cap = req_valid & req_ready;
            if (tx_valid && tx_ready) begin
                lg_idx.push_back(int'(grant_idx));
                lg_data.push_back(int'(tx_data));
                lg_cyc.push_back(cyc);
                $display("tx cyc=%0d req=%0d data=0x%02h", cyc, grant_idx, tx_data);
            end
            if (timeout_pulse) pulse_cyc.push_back(cyc);
            if (grant_valid && !prev_gv) begin
                gnt_idx_q.push_back(int'(grant_idx));
                gnt_cyc.push_back(cyc);
            end
            if (!grant_valid && prev_gv) gnt_end.push_back(cyc);
            prev_gv = grant_valid;
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (cap[i] && head[i] < tail[i]) head[i]++;
            end
            refresh();
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_grant_valid got=%b want=0", grant_valid); end
        n_vec++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant_idx got=%0d want=0", grant_idx); end
        n_vec++; if (timeout_pulse !== 1'b0) begin n_err++; $display("FAIL reset_timeout_pulse got=%b want=0", timeout_pulse); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got=%02h want=00", tx_data); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_request_grant got=%b want=0", grant_valid); end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3] = '{8'h48, 8'h69, 8'h0A};
        int c0;
        tx_ready = 1'b1;
        clear_logs();
        @(posedge clk); #2;
        c0 = cyc;
        push(0, 8'h48, 1'b0); push(0, 8'h69, 1'b0); push(0, 8'h0A, 1'b1);
        for (int t = 0; t < 40 && gnt_end.size() == 0; t++) begin @(negedge clk); #1; end
        n_vec++; if (gnt_end.size() == 0) begin n_err++; $display("FAIL single_release_wait got=none want=release"); end
        n_vec++; if (gnt_cyc.size() == 0 || gnt_cyc[0] != c0 + 1)
            begin n_err++; $display("FAIL single_grant_latency got=%0d want=1", gnt_cyc.size() > 0 ? gnt_cyc[0] - c0 : -1); end
        n_vec++; if (lg_data.size() != 3) begin n_err++; $display("FAIL single_byte_count got=%0d want=3", lg_data.size()); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (lg_data[k] != int'(exp_d[k]) || lg_idx[k] != 0)
                begin n_err++; $display("FAIL single_byte%0d got=%02h/req%0d want=%02h/req0", k, lg_data[k], lg_idx[k], exp_d[k]); end
        end
        n_vec++; if (gnt_end.size() == 0 || gnt_end[0] != lg_cyc[2] + 1)
            begin n_err++; $display("FAIL single_release_timing got=%0d want=%0d", gnt_end.size() > 0 ? gnt_end[0] : -1, lg_cyc[2] + 1); end
    endtask

    task automatic test_two_way();
        int exp_i [6] = '{1, 1, 1, 2, 2, 2};
        int exp_d [6] = '{'h11, 'h12, 'h13, 'h21, 'h22, 'h23};
        do_reset();
        tx_ready = 1'b1;
        @(posedge clk); #2;
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        for (int t = 0; t < 60 && gnt_end.size() < 2; t++) begin @(negedge clk); #1; end
        n_vec++; if (gnt_end.size() < 2) begin n_err++; $display("FAIL two_way_wait got=%0d releases want=2", gnt_end.size()); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (lg_idx[k] != exp_i[k] || lg_data[k] != exp_d[k])
                begin n_err++; $display("FAIL two_way_byte%0d got=req%0d/%02h want=req%0d/%02h", k, lg_idx[k], lg_data[k], exp_i[k], exp_d[k]); end
        end
        n_vec++; if (gnt_idx_q.size() != 2 || gnt_idx_q[0] != 1 || gnt_idx_q[1] != 2)
            begin n_err++; $display("FAIL two_way_grant_order got=%0d,%0d want=1,2", gnt_idx_q[0], gnt_idx_q[1]); end
        n_vec++; if (gnt_cyc[1] - gnt_end[0] != 1)
            begin n_err++; $display("FAIL two_way_idle_gap got=%0d want=1", gnt_cyc[1] - gnt_end[0]); end
    endtask

    task automatic test_back_to_back();
        int ei, ed;
        do_reset();
        tx_ready = 1'b1;
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            push(0, 8'hA0 + 8'(k), 1'b1);
            push(3, 8'hB0 + 8'(k), 1'b1);
        end
        for (int t = 0; t < 100 && gnt_end.size() < 8; t++) begin @(negedge clk); #1; end
        n_vec++; if (gnt_end.size() < 8) begin n_err++; $display("FAIL alt_wait got=%0d releases want=8", gnt_end.size()); end
        for (int k = 0; k < 8; k++) begin
            ei = (k % 2 == 0) ? 0 : 3;
            ed = ((k % 2 == 0) ? 'hA0 : 'hB0) + k / 2;
            n_vec++;
            if (gnt_idx_q[k] != ei || lg_data[k] != ed)
                begin n_err++; $display("FAIL alt_msg%0d got=req%0d/%02h want=req%0d/%02h", k, gnt_idx_q[k], lg_data[k], ei, ed); end
        end
    endtask

    task automatic test_backpressure();
        int bad, rise;
        tx_ready = 1'b1;
        clear_logs();
        @(posedge clk); #2;
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
        for (int t = 0; t < 20 && lg_data.size() < 1; t++) begin @(negedge clk); #1; end
        @(posedge clk); #2;
        tx_ready = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk); #1;
            if (req_ready !== 4'b0000 || tx_valid !== 1'b1 || tx_data !== 8'h32 || grant_idx !== 2'd1) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad); end
        n_vec++; if (pulse_cyc.size() != 0) begin n_err++; $display("FAIL bp_no_timeout got=%0d pulses want=0", pulse_cyc.size()); end
        @(posedge clk); #2;
        tx_ready = 1'b1;
        rise = cyc;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_ready_mirror got=%b want=0010", req_ready); end
        for (int t = 0; t < 20 && gnt_end.size() < 1; t++) begin @(negedge clk); #1; end
        n_vec++; if (lg_data[1] != 'h32 || lg_cyc[1] != rise)
            begin n_err++; $display("FAIL bp_resume got=%02h@%0d want=32@%0d", lg_data[1], lg_cyc[1], rise); end
        n_vec++; if (lg_data.size() != 3 || lg_data[2] != 'h33)
            begin n_err++; $display("FAIL bp_last got=%02h (n=%0d) want=33 (n=3)", lg_data[2], lg_data.size()); end
    endtask

    task automatic test_timeout();
        int exp_i [3] = '{2, 2, 0};
        int exp_d [3] = '{'h48, 'h65, 'h5A};
        clear_logs();
        tx_ready = 1'b1;
        @(posedge clk); #2;
        push(2, 8'h48, 1'b0); push(2, 8'h65, 1'b0);
        for (int t = 0; t < 10 && gnt_cyc.size() < 1; t++) begin @(negedge clk); #1; end
        @(posedge clk); #2;
        push(0, 8'h5A, 1'b1);
        for (int t = 0; t < 100 && pulse_cyc.size() < 1; t++) begin @(negedge clk); #1; end
        n_vec++; if (pulse_cyc.size() < 1) begin n_err++; $display("FAIL to_pulse_seen got=none want=pulse"); end
        for (int t = 0; t < 40 && gnt_end.size() < 2; t++) begin @(negedge clk); #1; end
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (gnt_idx_q[0] != 2) begin n_err++; $display("FAIL to_first_grant got=%0d want=2", gnt_idx_q[0]); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (lg_idx[k] != exp_i[k] || lg_data[k] != exp_d[k])
                begin n_err++; $display("FAIL to_byte%0d got=req%0d/%02h want=req%0d/%02h", k, lg_idx[k], lg_data[k], exp_i[k], exp_d[k]); end
        end
        n_vec++; if (pulse_cyc[0] - (lg_cyc[1] + 1) != 20)
            begin n_err++; $display("FAIL to_delay got=%0d want=20", pulse_cyc[0] - (lg_cyc[1] + 1)); end
        n_vec++; if (pulse_cyc.size() != 1) begin n_err++; $display("FAIL to_pulse_width got=%0d want=1", pulse_cyc.size()); end
        n_vec++; if (gnt_end[0] != pulse_cyc[0]) begin n_err++; $display("FAIL to_release got=%0d want=%0d", gnt_end[0], pulse_cyc[0]); end
        n_vec++; if (gnt_idx_q[1] != 0) begin n_err++; $display("FAIL to_next_grant got=%0d want=0", gnt_idx_q[1]); end
    endtask

    task automatic test_reset_mid();
        int exp_d [3] = '{'h72, 'h73, 'hD4};
        clear_logs();
        tx_ready = 1'b1;
        @(posedge clk); #2;
        push(2, 8'hC3, 1'b1);
        for (int t = 0; t < 20 && gnt_end.size() < 1; t++) begin @(negedge clk); #1; end
        @(posedge clk); #2;
        push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
        for (int t = 0; t < 20 && lg_data.size() < 2; t++) begin @(negedge clk); #1; end
        @(posedge clk); #2;
        tx_ready = 1'b0;
        push(3, 8'hD4, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (grant_valid !== 1'b1 || grant_idx !== 2'd1)
            begin n_err++; $display("FAIL mid_locked got=%b/%0d want=1/1", grant_valid, grant_idx); end
        @(posedge clk); #2;
        tx_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0010 || tx_data !== 8'h72)
            begin n_err++; $display("FAIL mid_pre_reset got=%b/%02h want=0010/72", req_ready, tx_data); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_grant got=%b want=0", grant_valid); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_tx_valid got=%b want=0", tx_valid); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_async_req_ready got=%b want=0000", req_ready); end
        repeat (3) @(posedge clk);
        #2;
        clear_logs();
        rst_n = 1'b1;
        for (int t = 0; t < 40 && gnt_end.size() < 2; t++) begin @(negedge clk); #1; end
        n_vec++; if (gnt_idx_q.size() < 2 || gnt_idx_q[0] != 1 || gnt_idx_q[1] != 3)
            begin n_err++; $display("FAIL mid_post_grants got=%0d,%0d want=1,3", gnt_idx_q[0], gnt_idx_q[1]); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (lg_data[k] != exp_d[k])
                begin n_err++; $display("FAIL mid_post_byte%0d got=%02h want=%02h", k, lg_data[k], exp_d[k]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        clear_bufs();
        test_reset();
        test_single();
        test_two_way();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
